// File: rtl/ps2_transmitter_pkg.sv
// ---------------------------------------------------------------------------
// ps2_transmitter_pkg
// Shared PS/2 definitions: the host-to-device transmitter state encoding,
// frame bit positions and a small elaboration-time helper.
// No ports (package).
// ---------------------------------------------------------------------------
package ps2_transmitter_pkg;

    // Host-to-device transmitter states.
    typedef enum logic [2:0] {
        TX_IDLE      = 3'd0,
        TX_INHIBIT   = 3'd1,
        TX_REQUEST   = 3'd2,
        TX_SHIFT     = 3'd3,
        TX_ACK       = 3'd4,
        TX_WAIT_IDLE = 3'd5,
        TX_RESPOND   = 3'd6
    } ps2_tx_state_t;

    // Bit index positions inside the shifted part of the frame:
    // 0..7 data (LSB first), 8 parity, 9 stop.
    localparam int unsigned TX_BIT_IDX_W  = 4;
    localparam logic [3:0]  TX_PARITY_IDX = 4'd8;
    localparam logic [3:0]  TX_STOP_IDX   = 4'd9;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clock_synchronizer.sv
// ---------------------------------------------------------------------------
// clock_synchronizer
// Two-flop synchronizer for a single asynchronous level (PS/2 pin).
// Ports:
//   i_clk        system clock
//   i_reset_low  synchronous active-low reset (flops load RESET_VALUE)
//   i_async      asynchronous input level
//   o_sync       synchronized level, two clk cycles of latency
// ---------------------------------------------------------------------------
module clock_synchronizer #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset_low,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_reset_low) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/ps2_transmitter.sv
// ---------------------------------------------------------------------------
// ps2_transmitter
// Host-to-device PS/2 frame transmitter. Accepts one command byte, inhibits
// the bus, issues a request-to-send, shifts start/data/parity/stop on the
// device's clock falling edges, samples the device ack and reports the result.
//
// Ports:
//   clk, reset_low             system clock, synchronous active-low reset
//   ps2_clk_in / ps2_data_in   raw PS/2 pin levels (asynchronous)
//   ps2_clk_out / ps2_data_out open-drain drive value, constant 0
//   ps2_clk_oe / ps2_data_oe   1 = pull the line low
//   command_ready/valid/byte   command input handshake
//   command_ack_ready/valid    result handshake, command_ack_error = failed
//   busy                       1 in every state except IDLE
//   dbg_state                  current FSM state
//
// Handshakes: a transfer happens on a clk edge where both valid and ready
// are 1. command_ready is 1 only in IDLE; command_valid is ignored elsewhere.
// command_ack_valid/command_ack_error are held stable until the edge where
// command_ack_ready is sampled 1; command_ready returns the cycle after.
// ---------------------------------------------------------------------------
module ps2_transmitter
    import ps2_transmitter_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 7425,
    parameter int unsigned TIMEOUT_CYCLES = 1113750
) (
    input  logic          clk,
    input  logic          reset_low,
    input  logic          ps2_clk_in,
    output logic          ps2_clk_out,
    output logic          ps2_clk_oe,
    input  logic          ps2_data_in,
    output logic          ps2_data_out,
    output logic          ps2_data_oe,
    output logic          command_ready,
    input  logic          command_valid,
    input  logic [7:0]    command_byte,
    input  logic          command_ack_ready,
    output logic          command_ack_valid,
    output logic          command_ack_error,
    output logic          busy,
    output ps2_tx_state_t dbg_state
);

    localparam int unsigned CNT_W = $clog2(max_u(INHIBIT_CYCLES, TIMEOUT_CYCLES) + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LOAD = CNT_W'(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES);

    // Synchronized pins and falling-edge detect
    logic w_clk_s;
    logic w_data_s;
    logic r_clk_prev;
    logic w_fall;

    // FSM and datapath
    ps2_tx_state_t           r_state;
    ps2_tx_state_t           w_state_next;
    logic [CNT_W-1:0]        r_cnt;
    logic [TX_BIT_IDX_W-1:0] r_bit_idx;
    logic [7:0]              r_byte;
    logic                    r_parity;
    logic                    r_err;
    logic                    w_accept;
    logic                    w_expire;
    logic                    w_timeout;
    logic                    w_cur_bit;

    // Registered outputs and their next values
    logic r_clk_oe,        w_clk_oe_d;
    logic r_data_oe,       w_data_oe_d;
    logic r_command_ready, w_command_ready_d;
    logic r_ack_valid,     w_ack_valid_d;
    logic r_ack_error,     w_ack_error_d;
    logic r_busy,          w_busy_d;

    clock_synchronizer #(.RESET_VALUE(1'b1)) u_sync_clk (
        .i_clk       (clk),
        .i_reset_low (reset_low),
        .i_async     (ps2_clk_in),
        .o_sync      (w_clk_s)
    );

    clock_synchronizer #(.RESET_VALUE(1'b1)) u_sync_data (
        .i_clk       (clk),
        .i_reset_low (reset_low),
        .i_async     (ps2_data_in),
        .o_sync      (w_data_s)
    );

    assign w_fall   = r_clk_prev & ~w_clk_s;
    assign w_accept = (r_state == TX_IDLE) && command_valid && r_command_ready;
    // The counter reaches 0 on this edge.
    assign w_expire = (r_cnt <= CNT_W'(1));

    // Bit to present after the current fall: data LSB first, parity, stop.
    always_comb begin
        w_cur_bit = 1'b1;
        if (r_bit_idx < TX_PARITY_IDX) begin
            w_cur_bit = r_byte[r_bit_idx[2:0]];
        end else if (r_bit_idx == TX_PARITY_IDX) begin
            w_cur_bit = r_parity;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_low) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            TX_IDLE: begin
                if (w_accept) w_state_next = TX_INHIBIT;
            end
            TX_INHIBIT: begin
                if (w_expire) w_state_next = TX_REQUEST;
            end
            TX_REQUEST: begin
                if (w_expire) w_timeout = 1'b1;
                else          w_state_next = TX_SHIFT;
            end
            TX_SHIFT: begin
                if (w_fall) begin
                    if (r_bit_idx == TX_STOP_IDX) w_state_next = TX_ACK;
                end else if (w_expire) begin
                    w_timeout = 1'b1;
                end
            end
            TX_ACK: begin
                if (w_fall)        w_state_next = TX_WAIT_IDLE;
                else if (w_expire) w_timeout = 1'b1;
            end
            TX_WAIT_IDLE: begin
                if (w_clk_s && w_data_s) w_state_next = TX_RESPOND;
                else if (w_expire)       w_timeout = 1'b1;
            end
            TX_RESPOND: begin
                if (command_ack_ready) w_state_next = TX_IDLE;
            end
            default: w_state_next = TX_IDLE;
        endcase
        if (w_timeout) w_state_next = TX_RESPOND;
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!reset_low) begin
            r_clk_prev <= 1'b1;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_byte     <= '0;
            r_parity   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_clk_prev <= w_clk_s;

            if (w_accept) begin
                r_cnt <= INHIBIT_LOAD;
            end else if ((w_state_next == TX_REQUEST) && (r_state != TX_REQUEST)) begin
                r_cnt <= TIMEOUT_LOAD;
            end else if (((r_state == TX_SHIFT) || (r_state == TX_ACK)) && w_fall) begin
                r_cnt <= TIMEOUT_LOAD;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (w_accept) begin
                r_byte   <= command_byte;
                r_parity <= ~^command_byte;
            end

            if (r_state == TX_INHIBIT) begin
                r_bit_idx <= '0;
            end else if ((r_state == TX_SHIFT) && w_fall && (r_bit_idx != TX_STOP_IDX)) begin
                r_bit_idx <= r_bit_idx + 4'd1;
            end

            // A timeout wins over whatever the ack bit said.
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end else if ((r_state == TX_ACK) && w_fall) begin
                r_err <= w_data_s;
            end
        end
    end

    // ---------------- output logic ----------------
    // Outputs are computed from the next state so the registered pins change
    // on the same edge as the state register.
    always_comb begin
        w_clk_oe_d        = (w_state_next == TX_INHIBIT);
        w_command_ready_d = (w_state_next == TX_IDLE);
        w_busy_d          = (w_state_next != TX_IDLE);
        w_ack_valid_d     = (w_state_next == TX_RESPOND);
        w_ack_error_d     = (w_state_next == TX_RESPOND) && (w_timeout || r_err);
        case (w_state_next)
            TX_REQUEST: w_data_oe_d = 1'b1;
            TX_SHIFT:   w_data_oe_d = ((r_state == TX_SHIFT) && w_fall) ? ~w_cur_bit : r_data_oe;
            default:    w_data_oe_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_low) begin
            r_clk_oe        <= 1'b0;
            r_data_oe       <= 1'b0;
            r_command_ready <= 1'b0;
            r_ack_valid     <= 1'b0;
            r_ack_error     <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_clk_oe        <= w_clk_oe_d;
            r_data_oe       <= w_data_oe_d;
            r_command_ready <= w_command_ready_d;
            r_ack_valid     <= w_ack_valid_d;
            r_ack_error     <= w_ack_error_d;
            r_busy          <= w_busy_d;
        end
    end

    assign ps2_clk_out       = 1'b0;
    assign ps2_data_out      = 1'b0;
    assign ps2_clk_oe        = r_clk_oe;
    assign ps2_data_oe       = r_data_oe;
    assign command_ready     = r_command_ready;
    assign command_ack_valid = r_ack_valid;
    assign command_ack_error = r_ack_error;
    assign busy              = r_busy;
    assign dbg_state         = r_state;

endmodule

// File: tb/tb_ps2_transmitter.sv
// ---------------------------------------------------------------------------
// tb_ps2_transmitter
// Drives command bytes into ps2_transmitter with a behavioural PS/2 device
// on an open-drain bus. Expected frames and ack results are queued when a
// command is issued; the device model and an ack monitor pop and compare.
// ---------------------------------------------------------------------------
module tb_ps2_transmitter;
    import ps2_transmitter_pkg::*;

    localparam int INH  = 20;
    localparam int TMO  = 1000;
    localparam int HALF = 40;

    localparam int MODE_ACK    = 0;
    localparam int MODE_NACK   = 1;
    localparam int MODE_SILENT = 2;
    localparam int MODE_ABORT  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_low = 1'b0;

    // ---------------- DUT and bus ----------------
    logic          dev_clk_low  = 1'b0;
    logic          dev_data_low = 1'b0;
    logic          ps2_clk_in, ps2_data_in;
    logic          ps2_clk_out, ps2_clk_oe, ps2_data_out, ps2_data_oe;
    logic          command_ready;
    logic          command_valid = 1'b0;
    logic [7:0]    command_byte  = 8'h00;
    logic          command_ack_ready = 1'b1;
    logic          command_ack_valid, command_ack_error, busy;
    ps2_tx_state_t dbg_state;

    assign ps2_clk_in  = ~(ps2_clk_oe  | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk               (clk),
        .reset_low         (reset_low),
        .ps2_clk_in        (ps2_clk_in),
        .ps2_clk_out       (ps2_clk_out),
        .ps2_clk_oe        (ps2_clk_oe),
        .ps2_data_in       (ps2_data_in),
        .ps2_data_out      (ps2_data_out),
        .ps2_data_oe       (ps2_data_oe),
        .command_ready     (command_ready),
        .command_valid     (command_valid),
        .command_byte      (command_byte),
        .command_ack_ready (command_ack_ready),
        .command_ack_valid (command_ack_valid),
        .command_ack_error (command_ack_error),
        .busy              (busy),
        .dbg_state         (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [10:0] exp_frame_q[$];
    logic [0:0]  exp_err_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame as the device sees it, in order: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b, 1'b0};
    endfunction

    // Ack monitor: compare each newly presented result against the queue.
    logic prev_ack_valid = 1'b0;
    always @(negedge clk) begin
        if (!reset_low) begin
            prev_ack_valid = 1'b0;
        end else begin
            if (command_ack_valid && !prev_ack_valid) begin
                if (exp_err_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL ack_unexpected: got ack error=%0b expected no ack", command_ack_error);
                end else begin
                    check("ack_error", command_ack_error, exp_err_q.pop_front());
                end
            end
            prev_ack_valid = command_ack_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_send(input logic [7:0] b, input int mode);
        int n;
        @(negedge clk);
        command_byte  = b;
        command_valid = 1'b1;
        if (mode == MODE_ACK || mode == MODE_NACK) exp_frame_q.push_back(model_frame(b));
        if (mode != MODE_ABORT) exp_err_q.push_back((mode == MODE_ACK) ? 1'b0 : 1'b1);
        @(negedge clk);
        command_valid = 1'b0;
        command_byte  = 8'($urandom_range(0, 255));
        check("accept_clk_oe", ps2_clk_oe, 1);
        check("accept_busy", {busy, command_ready}, 2'b10);
        n = 1;
        while (ps2_clk_oe && n < 200) begin
            @(negedge clk);
            if (ps2_clk_oe) n++;
        end
        check("inhibit_len", n, INH);
        check("request_data_oe", ps2_data_oe, 1);
    endtask

    task automatic dev_run(input int mode);
        int n;
        logic [10:0] obs;
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            check("request_seen", 0, 1);
            return;
        end
        if (mode == MODE_SILENT) return;
        repeat (5) @(negedge clk);
        obs = '0;
        for (int k = 0; k < 11; k++) begin
            repeat (HALF) @(negedge clk);
            obs[k] = ps2_data_in;
            if (mode == MODE_ABORT && k == 5) begin
                // Bit 4 is on the line; reset in the middle of the frame.
                check("abort_pre_data_oe", ps2_data_oe, 1);
                reset_low = 1'b0;
                @(negedge clk);
                check("abort_oe", {ps2_clk_oe, ps2_data_oe}, 0);
                check("abort_ready_low", command_ready, 0);
                reset_low = 1'b1;
                @(negedge clk);
                check("abort_ready_high", command_ready, 1);
                check("abort_no_ack", command_ack_valid, 0);
                return;
            end
            if (k == 10 && mode == MODE_ACK) begin
                dev_data_low = 1'b1;
                @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (k == 10) dev_data_low = 1'b0;
        end
        if (exp_frame_q.size() == 0) check("frame_unexpected", 1, 0);
        else check("frame_bits", obs, exp_frame_q.pop_front());
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!command_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("return_idle", command_ready, 1);
    endtask

    task automatic run_frame(input logic [7:0] b, input int mode);
        fork
            do_send(b, mode);
            dev_run(mode);
        join
        wait_idle();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got no end of test expected finish within 60000 cycles");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] b;
        logic       err0;
        logic       stable;
        logic       extra;
        int         n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_ready", command_ready, 0);
        check("rst_ack", {command_ack_valid, command_ack_error}, 0);
        check("rst_busy", busy, 0);
        check("drive_values", {ps2_clk_out, ps2_data_out}, 0);
        reset_low = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {command_ready, busy}, 2'b10);

        // 0xFF acked, 0xF4 nacked
        run_frame(8'hFF, MODE_ACK);
        run_frame(8'hF4, MODE_NACK);

        // Silent device: timeout after TMO cycles from the request
        b = 8'($urandom_range(0, 255));
        fork
            do_send(b, MODE_SILENT);
            dev_run(MODE_SILENT);
        join
        n = 0;
        while (!command_ack_valid && n < TMO + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TMO);
        check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("timeout_err", {command_ack_valid, command_ack_error}, 2'b11);
        wait_idle();

        // Consumer stalls the result for 50 cycles
        command_ack_ready = 1'b0;
        b = 8'($urandom_range(0, 255));
        fork
            do_send(b, MODE_ACK);
            dev_run(MODE_ACK);
        join
        n = 0;
        while (!command_ack_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid", command_ack_valid, 1);
        err0   = command_ack_error;
        stable = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (!command_ack_valid || command_ack_error !== err0 || command_ready) stable = 1'b0;
        end
        check("stall_stable", stable, 1);
        command_ack_ready = 1'b1;
        @(negedge clk);
        check("ready_after_ack", {command_ready, command_ack_valid}, 2'b10);

        // command_valid pulsed while busy is ignored
        b = 8'($urandom_range(0, 255));
        fork
            do_send(b, MODE_ACK);
            dev_run(MODE_ACK);
            begin
                repeat (300) @(negedge clk);
                command_byte  = 8'($urandom_range(0, 255));
                command_valid = 1'b1;
                repeat (3) @(negedge clk);
                command_valid = 1'b0;
            end
        join
        wait_idle();
        extra = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (ps2_clk_oe || busy) extra = 1'b1;
        end
        check("no_second_frame", extra, 0);

        // Random bytes with random ack/nack
        for (int i = 0; i < 4; i++) begin
            run_frame(8'($urandom_range(0, 255)), $urandom_range(0, 1));
        end

        // Reset during bit 4 (bit 4 forced to 0 so data_oe is asserted)
        b = 8'($urandom_range(0, 255)) & 8'hEF;
        fork
            do_send(b, MODE_ABORT);
            dev_run(MODE_ABORT);
        join
        repeat (20) @(negedge clk);

        // Recovery after the aborted frame
        run_frame(8'($urandom_range(0, 255)), MODE_ACK);

        repeat (10) @(negedge clk);
        check("queues_drained", exp_err_q.size() + exp_frame_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
